// File: rtl/rx_pkg.sv
// Shared defaults and width helper for the UART word receive path.
package rx_pkg;

  localparam int unsigned DEF_WORD_BYTES     = 4;
  localparam int unsigned DEF_BIG_ENDIAN     = 0;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;
  localparam int unsigned DEF_FIFO_DEPTH     = 4;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rx_word_fifo.sv
// Small synchronous word FIFO; full-with-pop accepts the push, output reads zero when empty.
module rx_word_fifo
  import rx_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                   clk12,
  input  logic                   rstn,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [clog2(DEPTH):0]  count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk12 or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk12) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/rx_word_assembler.sv
// Packs the uart_rx byte stream into WORD_BYTES-byte words, drops stale partial words
// after an idle timeout, and buffers completed words for a valid/ready consumer.
module rx_word_assembler
  import rx_pkg::*;
#(
  parameter int unsigned WORD_BYTES     = DEF_WORD_BYTES,
  parameter int unsigned BIG_ENDIAN     = DEF_BIG_ENDIAN,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned FIFO_DEPTH     = DEF_FIFO_DEPTH
) (
  input  logic                        clk12,
  input  logic                        rstn,
  input  logic [7:0]                  byte_data,
  input  logic                        byte_valid,
  output logic [8*WORD_BYTES-1:0]     word_data,
  output logic                        word_valid,
  input  logic                        word_ready,
  output logic [clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                        timeout_drop,
  output logic                        overflow,
  input  logic                        err_clear
);

  localparam int unsigned W  = 8 * WORD_BYTES;
  localparam int unsigned IW = (WORD_BYTES > 1) ? clog2(WORD_BYTES) : 1;
  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(WORD_BYTES - 1);
  localparam logic [CW-1:0] ToCount = CW'(TIMEOUT_CYCLES);

  function automatic logic [IW-1:0] lane_of(input logic [IW-1:0] idx);
    return (BIG_ENDIAN != 0) ? LastIdx - idx : idx;
  endfunction

  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          drop_q, drop_d;
  logic          ovf_q, ovf_d;
  logic          push, pop, full, empty, expire;

  assign expire = (TIMEOUT_CYCLES != 0) && (idx_q != '0) && (cnt_q == ToCount);

  // A byte in the expiry cycle takes priority over the drop.
  always_comb begin
    idx_d  = idx_q;
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    push   = 1'b0;
    drop_d = 1'b0;
    if (byte_valid) begin
      sr_d[8*lane_of(idx_q) +: 8] = byte_data;
      cnt_d = '0;
      if (idx_q == LastIdx) begin
        push  = 1'b1;
        idx_d = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else if (idx_q == '0) begin
      cnt_d = '0;
    end else if (expire) begin
      idx_d  = '0;
      cnt_d  = '0;
      drop_d = 1'b1;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign word_valid = ~empty;
  assign pop        = word_valid & word_ready;

  // New overflow wins over a simultaneous clear.
  always_comb begin
    ovf_d = ovf_q;
    if (err_clear)              ovf_d = 1'b0;
    if (push && full && !pop)   ovf_d = 1'b1;
  end

  always_ff @(posedge clk12 or negedge rstn) begin
    if (!rstn) begin
      idx_q  <= '0;
      sr_q   <= '0;
      cnt_q  <= '0;
      drop_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
      ovf_q  <= ovf_d;
    end
  end

  rx_word_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk12 (clk12),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .wdata (sr_d),
    .rdata (word_data),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  assign timeout_drop = drop_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_rx_word_assembler.sv
// Bench for rx_word_assembler: a 4-byte LE instance with a short timeout and a 2-byte BE
// instance, checked every cycle against a queue-based reference model.
module tb_rx_word_assembler;

  logic clk12 = 1'b0;
  always #5 clk12 = ~clk12;

  logic        rstn;
  logic        bv [2];
  logic        rdy[2];
  logic        clr[2];
  logic [7:0]  bd [2];

  logic [31:0] wd_a;
  logic [15:0] wd_b;
  logic        wv_a, wv_b, drop_a, drop_b, ovf_a, ovf_b;
  logic [2:0]  cnt_a, cnt_b;

  rx_word_assembler #(
    .WORD_BYTES     (4),
    .BIG_ENDIAN     (0),
    .TIMEOUT_CYCLES (16),
    .FIFO_DEPTH     (4)
  ) dut_a (
    .clk12        (clk12),
    .rstn         (rstn),
    .byte_data    (bd[0]),
    .byte_valid   (bv[0]),
    .word_data    (wd_a),
    .word_valid   (wv_a),
    .word_ready   (rdy[0]),
    .fifo_count   (cnt_a),
    .timeout_drop (drop_a),
    .overflow     (ovf_a),
    .err_clear    (clr[0])
  );

  rx_word_assembler #(
    .WORD_BYTES     (2),
    .BIG_ENDIAN     (1),
    .TIMEOUT_CYCLES (0),
    .FIFO_DEPTH     (4)
  ) dut_b (
    .clk12        (clk12),
    .rstn         (rstn),
    .byte_data    (bd[1]),
    .byte_valid   (bv[1]),
    .word_data    (wd_b),
    .word_valid   (wv_b),
    .word_ready   (rdy[1]),
    .fifo_count   (cnt_b),
    .timeout_drop (drop_b),
    .overflow     (ovf_b),
    .err_clear    (clr[1])
  );

  int total = 0;
  int bad   = 0;
  int cycle = 0;
  int drops_seen[2];

  // Reference model state: pending bytes, buffered words, idle cycles, flags.
  logic [7:0]  m_part[2][$];
  logic [31:0] m_fifo[2][$];
  int          m_idle[2];
  logic        m_ovf [2];
  logic        m_drop[2];

  typedef struct {
    logic        bv;
    logic [7:0]  bd;
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [2:0]  exp_count;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cycle %0d: got %h want %h", name, id, cycle, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int id = 0; id < 2; id++) begin
      m_part[id].delete();
      m_fifo[id].delete();
      m_idle[id] = 0;
      m_ovf[id]  = 1'b0;
      m_drop[id] = 1'b0;
    end
  endtask

  task automatic model_step(input int id);
    int          wb, to;
    bit          be, pop, novf, ndrop;
    logic [31:0] w;
    wb    = (id == 0) ? 4 : 2;
    be    = (id == 1);
    to    = (id == 0) ? 16 : 0;
    pop   = (m_fifo[id].size() != 0) && rdy[id];
    novf  = 1'b0;
    ndrop = 1'b0;
    if (pop) void'(m_fifo[id].pop_front());
    if (bv[id]) begin
      m_part[id].push_back(bd[id]);
      m_idle[id] = 0;
      if (m_part[id].size() == wb) begin
        w = '0;
        for (int i = 0; i < wb; i++) begin
          if (be) w = (w << 8) | 32'(m_part[id][i]);
          else    w = w | (32'(m_part[id][i]) << (8 * i));
        end
        if (m_fifo[id].size() < 4) m_fifo[id].push_back(w);
        else                       novf = 1'b1;
        m_part[id].delete();
      end
    end else if (m_part[id].size() != 0) begin
      if (to != 0 && m_idle[id] == to) begin
        m_part[id].delete();
        m_idle[id] = 0;
        ndrop      = 1'b1;
      end else begin
        m_idle[id]++;
      end
    end
    m_ovf[id]  = novf ? 1'b1 : (clr[id] ? 1'b0 : m_ovf[id]);
    m_drop[id] = ndrop;
  endtask

  task automatic check_dut(input int id);
    logic        v, dr, ov;
    logic [31:0] d, c;
    if (id == 0) begin
      v = wv_a; d = wd_a; c = 32'(cnt_a); dr = drop_a; ov = ovf_a;
    end else begin
      v = wv_b; d = 32'(wd_b); c = 32'(cnt_b); dr = drop_b; ov = ovf_b;
    end
    chk("word_valid", id, 32'(v), 32'(m_fifo[id].size() != 0));
    if (m_fifo[id].size() != 0) chk("word_data", id, d, m_fifo[id][0]);
    chk("fifo_count", id, c, 32'(m_fifo[id].size()));
    chk("overflow", id, 32'(ov), 32'(m_ovf[id]));
    chk("timeout_drop", id, 32'(dr), 32'(m_drop[id]));
    if (dr) drops_seen[id]++;
  endtask

  task automatic cyc();
    model_step(0);
    model_step(1);
    @(posedge clk12);
    #1;
    cycle++;
    check_dut(0);
    check_dut(1);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    model_clear();
    check_dut(0);
    check_dut(1);
    chk("reset word_data", 0, wd_a, 32'h0);
    chk("reset word_data", 1, 32'(wd_b), 32'h0);
    @(posedge clk12);
    #1;
    rstn = 1'b1;
  endtask

  task automatic send(input int id, input logic [7:0] b);
    bv[id] = 1'b1;
    bd[id] = b;
    cyc();
    bv[id] = 1'b0;
  endtask

  // Word n is bytes n, n+0x10, n+0x20, n+0x30.
  task automatic send_word_a(input logic [7:0] n);
    for (int i = 0; i < 4; i++) send(0, n + 8'(16 * i));
  endtask

  function automatic logic [31:0] word_a(input logic [7:0] n);
    return 32'h3020_1000 + 32'h0101_0101 * 32'(n);
  endfunction

  task automatic pop_check(input int id, input logic [31:0] exp);
    chk("head", id, (id == 0) ? wd_a : 32'(wd_b), exp);
    rdy[id] = 1'b1;
    cyc();
    rdy[id] = 1'b0;
  endtask

  initial begin
    int p;
    rstn = 1'b0;
    for (int id = 0; id < 2; id++) begin
      bv[id] = 1'b0; bd[id] = 8'h00; rdy[id] = 1'b0; clr[id] = 1'b0; drops_seen[id] = 0;
    end
    do_reset();

    // LE word with ready held high: valid for exactly one cycle.
    vecs[0] = '{1'b1, 8'h13, 1'b1, 1'b0, 32'h0, 3'd0};
    vecs[1] = '{1'b1, 8'h05, 1'b1, 1'b0, 32'h0, 3'd0};
    vecs[2] = '{1'b1, 8'h10, 1'b1, 1'b0, 32'h0, 3'd0};
    vecs[3] = '{1'b1, 8'h00, 1'b1, 1'b1, 32'h0010_0513, 3'd1};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 3'd0};
    for (int i = 0; i < 5; i++) begin
      bv[0] = vecs[i].bv; bd[0] = vecs[i].bd; rdy[0] = vecs[i].rdy;
      cyc();
      chk("tbl_valid", 0, 32'(wv_a), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) chk("tbl_data", 0, wd_a, vecs[i].exp_data);
      chk("tbl_count", 0, 32'(cnt_a), 32'(vecs[i].exp_count));
    end
    bv[0] = 1'b0; rdy[0] = 1'b0;

    // Big-endian 2-byte word.
    send(1, 8'hAB);
    send(1, 8'hCD);
    pop_check(1, 32'h0000_ABCD);

    // Timeout drops the stale pair; the next word is clean.
    drops_seen[0] = 0;
    send(0, 8'hAA);
    send(0, 8'hBB);
    repeat (20) cyc();
    chk("drop_count", 0, 32'(drops_seen[0]), 32'd1);
    send(0, 8'h01); send(0, 8'h02); send(0, 8'h03); send(0, 8'h04);
    pop_check(0, 32'h0403_0201);

    // Byte arriving in the expiry cycle is kept.
    drops_seen[0] = 0;
    send(0, 8'h55);
    repeat (16) cyc();
    send(0, 8'h66); send(0, 8'h77); send(0, 8'h88);
    chk("expiry_drops", 0, 32'(drops_seen[0]), 32'd0);
    pop_check(0, 32'h8877_6655);

    // Overflow: fifth word lost, flag sticky until cleared.
    for (int n = 1; n <= 5; n++) send_word_a(8'(n));
    chk("ovf_count", 0, 32'(cnt_a), 32'd4);
    chk("ovf_flag", 0, 32'(ovf_a), 32'd1);
    for (int n = 1; n <= 4; n++) pop_check(0, word_a(8'(n)));
    chk("drained_valid", 0, 32'(wv_a), 32'd0);
    chk("ovf_sticky", 0, 32'(ovf_a), 32'd1);
    clr[0] = 1'b1;
    cyc();
    clr[0] = 1'b0;
    chk("ovf_cleared", 0, 32'(ovf_a), 32'd0);

    // Full FIFO with simultaneous pop and completing byte.
    for (int n = 1; n <= 4; n++) send_word_a(8'(n));
    send(0, 8'h05); send(0, 8'h15); send(0, 8'h25);
    rdy[0] = 1'b1;
    send(0, 8'h35);
    rdy[0] = 1'b0;
    chk("fullpop_count", 0, 32'(cnt_a), 32'd4);
    chk("fullpop_ovf", 0, 32'(ovf_a), 32'd0);
    for (int n = 2; n <= 5; n++) pop_check(0, word_a(8'(n)));

    // Reset mid-word with a word buffered; only the fresh word survives.
    send_word_a(8'h07);
    send(0, 8'hDE);
    send(0, 8'hAD);
    do_reset();
    send_word_a(8'h09);
    chk("post_reset_count", 0, 32'(cnt_a), 32'd1);
    pop_check(0, word_a(8'h09));

    // Randomised traffic in phases of dense, medium and sparse bytes.
    for (int c = 0; c < 3000; c++) begin
      p = ((c / 250) % 3 == 0) ? 85 : (((c / 250) % 3 == 1) ? 30 : 4);
      for (int id = 0; id < 2; id++) begin
        bv[id]  = ($urandom_range(0, 99) < p);
        bd[id]  = 8'($urandom);
        rdy[id] = ($urandom_range(0, 99) < (((c / 500) % 2 == 1) ? 70 : 15));
        clr[id] = ($urandom_range(0, 19) == 0);
      end
      cyc();
    end
    for (int id = 0; id < 2; id++) begin
      bv[id] = 1'b0; rdy[id] = 1'b1; clr[id] = 1'b0;
    end
    repeat (8) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
